// File: rtl/game_fsm_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : game_pkg
// Purpose  : Shared definitions for the brick-breaker game-flow controller:
//            game status codes, the FSM state type and a width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  localparam int GS_W = 3;

  localparam logic [GS_W-1:0] GS_IDLE        = 3'd0;
  localparam logic [GS_W-1:0] GS_SERVE       = 3'd1;
  localparam logic [GS_W-1:0] GS_PLAY        = 3'd2;
  localparam logic [GS_W-1:0] GS_PAUSE       = 3'd3;
  localparam logic [GS_W-1:0] GS_LEVEL_CLEAR = 3'd4;
  localparam logic [GS_W-1:0] GS_GAME_OVER   = 3'd5;
  localparam logic [GS_W-1:0] GS_WIN         = 3'd6;

  typedef enum logic [GS_W-1:0] {
    ST_IDLE        = GS_IDLE,
    ST_SERVE       = GS_SERVE,
    ST_PLAY        = GS_PLAY,
    ST_PAUSE       = GS_PAUSE,
    ST_LEVEL_CLEAR = GS_LEVEL_CLEAR,
    ST_GAME_OVER   = GS_GAME_OVER,
    ST_WIN         = GS_WIN
  } state_t;

  // max(1, $clog2(n)): a counter for a single level still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_fsm_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : game_fsm_ctrl_if
// Purpose  : Bundles the game controller's event inputs and status outputs.
// Ports    : master - drives start_btn, pause_btn, frame_tick, strike_brick,
//                     fall_down; observes status outputs.
//            slave  - the controller side (inverse directions).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface game_fsm_ctrl_if
  import game_pkg::*;
#(
  parameter int LIVES   = 3,
  parameter int LEVELS  = 2,
  parameter int BRICKS  = 4,
  parameter int SCORE_W = 16
) ();

  localparam int c_liv_w = $clog2(LIVES + 1);
  localparam int c_lvl_w = clog2_min1(LEVELS);
  localparam int c_brk_w = $clog2(BRICKS + 1);

  logic               start_btn;
  logic               pause_btn;
  logic               frame_tick;
  logic               strike_brick;
  logic               fall_down;
  logic [GS_W-1:0]    game_status;
  logic [c_liv_w-1:0] lives_left;
  logic [c_lvl_w-1:0] level;
  logic [c_brk_w-1:0] bricks_left;
  logic [SCORE_W-1:0] score;
  logic               ball_reset;
  logic               ball_en;

  modport master (
    output start_btn, pause_btn, frame_tick, strike_brick, fall_down,
    input  game_status, lives_left, level, bricks_left, score,
           ball_reset, ball_en
  );

  modport slave (
    input  start_btn, pause_btn, frame_tick, strike_brick, fall_down,
    output game_status, lives_left, level, bricks_left, score,
           ball_reset, ball_en
  );

endinterface

`default_nettype wire

// File: rtl/game_fsm_ctrl_btn_edge.sv
//------------------------------------------------------------------------------
// Module   : btn_edge
// Purpose  : Single-bit rising-edge detector; a held button yields one event.
// Ports    : clk, rst_n (async active-low), btn (clk-synchronous level),
//            rise (combinational, high for the first cycle btn is high).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= btn;
  end

  assign rise = btn & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/game_fsm_ctrl.sv
//------------------------------------------------------------------------------
// Module   : game_fsm_ctrl
// Purpose  : Brick-breaker game-flow controller: lives, levels, brick count,
//            saturating score, serve delay and button edge handling.
// Ports    : clk   - system clock
//            rst_n - asynchronous active-low reset
//            bus   - slave side of game_fsm_ctrl_if (button levels, frame
//                    tick, strike/fall pulses in; status, lives, level,
//                    bricks, score, ball_reset, ball_en out)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module game_fsm_ctrl
  import game_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int LEVELS       = 2,
  parameter int BRICKS       = 4,
  parameter int BRICK_PTS    = 10,
  parameter int SCORE_W      = 16,
  parameter int SERVE_FRAMES = 2
) (
  input logic            clk,
  input logic            rst_n,
  game_fsm_ctrl_if.slave bus
);

  localparam int c_liv_w = $clog2(LIVES + 1);
  localparam int c_lvl_w = clog2_min1(LEVELS);
  localparam int c_brk_w = $clog2(BRICKS + 1);
  localparam int c_cnt_w = $clog2(SERVE_FRAMES + 1);
  // Wide enough that the addition can never wrap, whatever BRICK_PTS is.
  localparam int c_sum_w = SCORE_W + 32;

  state_t             r_state,      w_state_nxt;
  logic [c_liv_w-1:0] r_lives,      w_lives_nxt;
  logic [c_lvl_w-1:0] r_level,      w_level_nxt;
  logic [c_brk_w-1:0] r_bricks,     w_bricks_nxt;
  logic [SCORE_W-1:0] r_score,      w_score_nxt;
  logic               r_ball_reset, w_ball_reset_nxt;
  logic [c_cnt_w-1:0] r_cnt,        w_cnt_nxt;

  logic               w_start_rise;
  logic               w_pause_rise;
  logic [c_sum_w-1:0] w_sum;
  logic [SCORE_W-1:0] w_score_inc;
  logic               w_frames_done;
  logic [c_cnt_w-1:0] w_cnt_step;
  logic               w_last_brick;

  btn_edge u_start_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bus.start_btn),
    .rise (w_start_rise)
  );

  btn_edge u_pause_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bus.pause_btn),
    .rise (w_pause_rise)
  );

  assign w_sum       = c_sum_w'(r_score) + c_sum_w'(BRICK_PTS);
  assign w_score_inc = (|w_sum[c_sum_w-1:SCORE_W]) ? {SCORE_W{1'b1}}
                                                   : w_sum[SCORE_W-1:0];

  // The counter holds ticks already seen, so this tick completes the delay.
  assign w_frames_done = bus.frame_tick && (r_cnt == c_cnt_w'(SERVE_FRAMES - 1));
  assign w_cnt_step    = bus.frame_tick ? r_cnt + c_cnt_w'(1) : r_cnt;
  assign w_last_brick  = bus.strike_brick && (r_bricks == c_brk_w'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_lives      <= c_liv_w'(LIVES);
      r_level      <= '0;
      r_bricks     <= c_brk_w'(BRICKS);
      r_score      <= '0;
      r_ball_reset <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lives      <= w_lives_nxt;
      r_level      <= w_level_nxt;
      r_bricks     <= w_bricks_nxt;
      r_score      <= w_score_nxt;
      r_ball_reset <= w_ball_reset_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_lives_nxt      = r_lives;
    w_level_nxt      = r_level;
    w_bricks_nxt     = r_bricks;
    w_score_nxt      = r_score;
    w_ball_reset_nxt = 1'b0;
    w_cnt_nxt        = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_lives_nxt      = c_liv_w'(LIVES);
          w_level_nxt      = '0;
          w_bricks_nxt     = c_brk_w'(BRICKS);
          w_score_nxt      = '0;
          w_ball_reset_nxt = 1'b1;
          w_state_nxt      = ST_SERVE;
        end
      end

      ST_SERVE: begin
        w_cnt_nxt = w_cnt_step;
        if (w_frames_done) w_state_nxt = ST_PLAY;
      end

      ST_PLAY: begin
        // Any strike is scored, even when a fall or pause wins the cycle.
        if (bus.strike_brick) begin
          w_score_nxt  = w_score_inc;
          w_bricks_nxt = r_bricks - c_brk_w'(1);
        end
        if (w_last_brick) begin
          w_state_nxt = (r_level == c_lvl_w'(LEVELS - 1)) ? ST_WIN : ST_LEVEL_CLEAR;
        end else if (bus.fall_down) begin
          w_lives_nxt = r_lives - c_liv_w'(1);
          if (r_lives == c_liv_w'(1)) begin
            w_state_nxt = ST_GAME_OVER;
          end else begin
            w_ball_reset_nxt = 1'b1;
            w_state_nxt      = ST_SERVE;
          end
        end else if (w_pause_rise) begin
          w_state_nxt = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (w_pause_rise) w_state_nxt = ST_PLAY;
      end

      ST_LEVEL_CLEAR: begin
        w_cnt_nxt = w_cnt_step;
        if (w_frames_done) begin
          w_level_nxt      = r_level + c_lvl_w'(1);
          w_bricks_nxt     = c_brk_w'(BRICKS);
          w_ball_reset_nxt = 1'b1;
          w_state_nxt      = ST_SERVE;
        end
      end

      ST_GAME_OVER, ST_WIN: begin
        if (w_start_rise) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  assign bus.game_status = r_state;
  assign bus.lives_left  = r_lives;
  assign bus.level       = r_level;
  assign bus.bricks_left = r_bricks;
  assign bus.score       = r_score;
  assign bus.ball_reset  = r_ball_reset;
  assign bus.ball_en     = (r_state == ST_PLAY);

endmodule

`default_nettype wire

// File: tb/tb_game_fsm_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_game_fsm_ctrl
// Purpose  : Self-checking bench for game_fsm_ctrl. Two instances share one
//            stimulus stream: default parameters and a 5-bit score variant.
// Ports    : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_game_fsm_ctrl;

  localparam int LIVES  = 3;
  localparam int LEVELS = 2;
  localparam int BRICKS = 4;
  localparam int PTS    = 10;
  localparam int SF     = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  game_fsm_ctrl_if #(.LIVES(LIVES), .LEVELS(LEVELS), .BRICKS(BRICKS), .SCORE_W(16)) bus0 ();
  game_fsm_ctrl_if #(.LIVES(LIVES), .LEVELS(LEVELS), .BRICKS(BRICKS), .SCORE_W(5))  bus1 ();

  assign bus1.start_btn    = bus0.start_btn;
  assign bus1.pause_btn    = bus0.pause_btn;
  assign bus1.frame_tick   = bus0.frame_tick;
  assign bus1.strike_brick = bus0.strike_brick;
  assign bus1.fall_down    = bus0.fall_down;

  game_fsm_ctrl #(
    .LIVES(LIVES), .LEVELS(LEVELS), .BRICKS(BRICKS), .BRICK_PTS(PTS),
    .SCORE_W(16), .SERVE_FRAMES(SF)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  game_fsm_ctrl #(
    .LIVES(LIVES), .LEVELS(LEVELS), .BRICKS(BRICKS), .BRICK_PTS(PTS),
    .SCORE_W(5), .SERVE_FRAMES(SF)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (one per instance) ----------------
  int m_st[2], m_lv[2], m_lev[2], m_bk[2], m_sc[2], m_br[2], m_cnt[2];
  bit m_ps[2], m_pp[2];
  int m_smax[2] = '{65535, 31};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_lv[i] = LIVES; m_lev[i] = 0; m_bk[i] = BRICKS;
      m_sc[i] = 0; m_br[i] = 0; m_cnt[i] = 0; m_ps[i] = 0; m_pp[i] = 0;
    end
  endtask

  task automatic model_step();
    bit s, p, t, k, f, sr, pr;
    int prev;
    s = bus0.start_btn; p = bus0.pause_btn; t = bus0.frame_tick;
    k = bus0.strike_brick; f = bus0.fall_down;
    for (int i = 0; i < 2; i++) begin
      sr = s && !m_ps[i];
      pr = p && !m_pp[i];
      m_ps[i] = s; m_pp[i] = p;
      m_br[i] = 0;
      prev = m_st[i];
      if (m_st[i] == 0) begin
        if (sr) begin
          m_lv[i] = LIVES; m_lev[i] = 0; m_bk[i] = BRICKS; m_sc[i] = 0;
          m_br[i] = 1; m_st[i] = 1;
        end
      end else if (m_st[i] == 1 || m_st[i] == 4) begin
        if (t) begin
          m_cnt[i]++;
          if (m_cnt[i] == SF) begin
            if (m_st[i] == 4) begin
              m_lev[i]++; m_bk[i] = BRICKS; m_br[i] = 1; m_st[i] = 1;
            end else begin
              m_st[i] = 2;
            end
          end
        end
      end else if (m_st[i] == 2) begin
        bit last;
        last = k && m_bk[i] == 1;
        if (k) begin
          m_sc[i] = (m_sc[i] + PTS > m_smax[i]) ? m_smax[i] : m_sc[i] + PTS;
          m_bk[i]--;
        end
        if (last) m_st[i] = (m_lev[i] == LEVELS - 1) ? 6 : 4;
        else if (f) begin
          m_lv[i]--;
          if (m_lv[i] == 0) m_st[i] = 5;
          else begin m_br[i] = 1; m_st[i] = 1; end
        end else if (pr) m_st[i] = 3;
      end else if (m_st[i] == 3) begin
        if (pr) m_st[i] = 2;
      end else begin
        if (sr) m_st[i] = 0;
      end
      if (m_st[i] != prev) m_cnt[i] = 0;
    end
  endtask

  task automatic check_model(input int k, input int st, input int lv, input int lev,
                             input int bk, input int sc, input int br, input int en);
    n_tests++;
    if (st != m_st[k] || lv != m_lv[k] || lev != m_lev[k] || bk != m_bk[k] ||
        sc != m_sc[k] || br != m_br[k] || en != int'(m_st[k] == 2)) begin
      n_fail++;
      $display("FAIL model%0d @%0t: got st=%0d lives=%0d lvl=%0d bricks=%0d score=%0d br=%0d en=%0d, expected st=%0d lives=%0d lvl=%0d bricks=%0d score=%0d br=%0d en=%0d",
               k, $time, st, lv, lev, bk, sc, br, en,
               m_st[k], m_lv[k], m_lev[k], m_bk[k], m_sc[k], m_br[k], int'(m_st[k] == 2));
    end
  endtask

  task automatic check_both();
    check_model(0, int'(bus0.game_status), int'(bus0.lives_left), int'(bus0.level),
                int'(bus0.bricks_left), int'(bus0.score), int'(bus0.ball_reset), int'(bus0.ball_en));
    check_model(1, int'(bus1.game_status), int'(bus1.lives_left), int'(bus1.level),
                int'(bus1.bricks_left), int'(bus1.score), int'(bus1.ball_reset), int'(bus1.ball_en));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_both();
  endtask

  task automatic drive(input bit s, input bit p, input bit t, input bit k, input bit f);
    bus0.start_btn = s; bus0.pause_btn = p; bus0.frame_tick = t;
    bus0.strike_brick = k; bus0.fall_down = f;
    cyc();
  endtask

  task automatic expect0(input string nm, input int st, input int lv, input int sc);
    n_tests++;
    if (int'(bus0.game_status) != st || int'(bus0.lives_left) != lv || int'(bus0.score) != sc) begin
      n_fail++;
      $display("FAIL %s: got st=%0d lives=%0d score=%0d, expected st=%0d lives=%0d score=%0d",
               nm, bus0.game_status, bus0.lives_left, bus0.score, st, lv, sc);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit s, p, t, k, f;
    int st, lv, lev, bk, sc, sc1, br;
  } vec_t;

  vec_t vec[22];

  function automatic vec_t mk(input bit s, input bit p, input bit t, input bit k, input bit f,
                              input int st, input int lv, input int lev, input int bk,
                              input int sc, input int sc1, input int br);
    vec_t v;
    v.s = s; v.p = p; v.t = t; v.k = k; v.f = f;
    v.st = st; v.lv = lv; v.lev = lev; v.bk = bk; v.sc = sc; v.sc1 = sc1; v.br = br;
    return v;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //           s  p  t  k  f   st lv lev bk sc  sc1 br
    vec[0]  = mk(1, 0, 0, 0, 0,  1, 3, 0, 4, 0,  0,  1);
    vec[1]  = mk(1, 0, 0, 0, 0,  1, 3, 0, 4, 0,  0,  0);
    vec[2]  = mk(1, 0, 0, 0, 0,  1, 3, 0, 4, 0,  0,  0);
    vec[3]  = mk(1, 0, 0, 0, 0,  1, 3, 0, 4, 0,  0,  0);
    vec[4]  = mk(1, 0, 0, 0, 0,  1, 3, 0, 4, 0,  0,  0);
    vec[5]  = mk(0, 0, 1, 0, 0,  1, 3, 0, 4, 0,  0,  0);
    vec[6]  = mk(0, 0, 1, 0, 0,  2, 3, 0, 4, 0,  0,  0);
    vec[7]  = mk(0, 0, 0, 1, 0,  2, 3, 0, 3, 10, 10, 0);
    vec[8]  = mk(0, 0, 0, 1, 0,  2, 3, 0, 2, 20, 20, 0);
    vec[9]  = mk(0, 0, 0, 1, 0,  2, 3, 0, 1, 30, 30, 0);
    vec[10] = mk(0, 0, 0, 1, 0,  4, 3, 0, 0, 40, 31, 0);
    vec[11] = mk(0, 0, 1, 0, 0,  4, 3, 0, 0, 40, 31, 0);
    vec[12] = mk(0, 0, 1, 0, 0,  1, 3, 1, 4, 40, 31, 1);
    vec[13] = mk(0, 0, 1, 0, 0,  1, 3, 1, 4, 40, 31, 0);
    vec[14] = mk(0, 0, 1, 0, 0,  2, 3, 1, 4, 40, 31, 0);
    vec[15] = mk(0, 0, 0, 1, 0,  2, 3, 1, 3, 50, 31, 0);
    vec[16] = mk(0, 0, 0, 1, 0,  2, 3, 1, 2, 60, 31, 0);
    vec[17] = mk(0, 0, 0, 1, 0,  2, 3, 1, 1, 70, 31, 0);
    vec[18] = mk(0, 0, 0, 1, 0,  6, 3, 1, 0, 80, 31, 0);
    vec[19] = mk(1, 0, 0, 0, 0,  0, 3, 1, 0, 80, 31, 0);
    vec[20] = mk(0, 0, 0, 0, 0,  0, 3, 1, 0, 80, 31, 0);
    vec[21] = mk(1, 0, 0, 0, 0,  1, 3, 0, 4, 0,  0,  1);

    bus0.start_btn = 0; bus0.pause_btn = 0; bus0.frame_tick = 0;
    bus0.strike_brick = 0; bus0.fall_down = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_both();

    // Reset state against constants
    n_tests++;
    if (bus0.game_status != 3'd0 || bus0.lives_left != 2'd3 || bus0.level != 1'b0 ||
        bus0.bricks_left != 3'd4 || bus0.score != 16'd0 || bus0.ball_reset || bus0.ball_en) begin
      n_fail++;
      $display("FAIL reset: got st=%0d lives=%0d lvl=%0d bricks=%0d score=%0d br=%0d en=%0d, expected 0 3 0 4 0 0 0",
               bus0.game_status, bus0.lives_left, bus0.level, bus0.bricks_left,
               bus0.score, bus0.ball_reset, bus0.ball_en);
    end

    for (int i = 0; i < 22; i++) begin
      drive(vec[i].s, vec[i].p, vec[i].t, vec[i].k, vec[i].f);
      n_tests++;
      if (int'(bus0.game_status) != vec[i].st || int'(bus0.lives_left) != vec[i].lv ||
          int'(bus0.level) != vec[i].lev || int'(bus0.bricks_left) != vec[i].bk ||
          int'(bus0.score) != vec[i].sc || int'(bus1.score) != vec[i].sc1 ||
          int'(bus0.ball_reset) != vec[i].br) begin
        n_fail++;
        $display("FAIL vec[%0d]: got st=%0d lives=%0d lvl=%0d bricks=%0d score=%0d score5=%0d br=%0d, expected %0d %0d %0d %0d %0d %0d %0d",
                 i, bus0.game_status, bus0.lives_left, bus0.level, bus0.bricks_left,
                 bus0.score, bus1.score, bus0.ball_reset,
                 vec[i].st, vec[i].lv, vec[i].lev, vec[i].bk, vec[i].sc, vec[i].sc1, vec[i].br);
      end
    end

    // Lives: three falls with re-serve in between
    drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0); expect0("serve_to_play", 2, 3, 0);
    drive(0, 0, 0, 0, 1); expect0("fall1", 1, 2, 0);
    drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1); expect0("fall2", 1, 1, 0);
    drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1); expect0("fall3_game_over", 5, 0, 0);
    drive(1, 0, 0, 0, 0); expect0("game_over_to_idle", 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Pause masks strike/fall; held pause is one event
    drive(1, 0, 0, 0, 0); expect0("start2", 1, 3, 0);
    drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0); expect0("pause_enter", 3, 3, 0);
    drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0); expect0("pause_held", 3, 3, 0);
    drive(0, 0, 0, 1, 0); expect0("pause_mask_strike", 3, 3, 0);
    drive(0, 0, 0, 0, 1); expect0("pause_mask_fall", 3, 3, 0);
    drive(0, 1, 0, 0, 0); expect0("pause_exit", 2, 3, 0);
    drive(0, 0, 0, 0, 0);

    // Last brick and fall in the same cycle: the clear wins
    drive(0, 0, 0, 1, 0); drive(0, 0, 0, 1, 0); drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1); expect0("last_strike_and_fall", 4, 3, 40);
    drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0); expect0("level_clear_done", 1, 3, 40);
    drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0);
    // Non-final strike and fall together: both take effect
    drive(0, 0, 0, 1, 1); expect0("strike_and_fall", 1, 2, 50);

    // Asynchronous reset mid-PLAY, checked before any further clock edge
    drive(0, 0, 1, 0, 0); drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0); expect0("pre_async_reset", 2, 2, 60);
    bus0.strike_brick = 0;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus0.game_status != 3'd0 || bus0.lives_left != 2'd3 || bus0.level != 1'b0 ||
        bus0.bricks_left != 3'd4 || bus0.score != 16'd0 || bus0.ball_reset ||
        bus0.ball_en || bus1.score != 5'd0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%0d lives=%0d lvl=%0d bricks=%0d score=%0d score5=%0d en=%0d, expected 0 3 0 4 0 0 0",
               bus0.game_status, bus0.lives_left, bus0.level, bus0.bricks_left,
               bus0.score, bus1.score, bus0.ball_en);
    end
    model_reset();
    #1 rst_n = 1'b1;

    // Randomized stimulus against the model
    begin
      bit s, p;
      s = 0; p = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) s = ~s;
        if ($urandom_range(0, 7) == 0) p = ~p;
        drive(s, p, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_fsm_ctrl.md
Name: game_fsm_ctrl

Overview:
- Parametrised game-flow controller for the brick-breaker game; successor to the basic Idle/Start/Pause controller.
- Adds lives, multiple levels, brick accounting, score, serve delay and start/pause buttons with internal edge detection.
- Sits between the button debouncers / ball-collision logic and the VGA renderer / score display.
- Drives game status plus ball reset/enable.

Parameters:
- LIVES, 3, lives per game (>=1)
- LEVELS, 2, number of levels (>=1)
- BRICKS, 4, bricks per level (>=1)
- BRICK_PTS, 10, score added per brick
- SCORE_W, 16, score width
- SERVE_FRAMES, 2, frame_tick count spent in SERVE / LEVEL_CLEAR (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_btn  in  1  debounced, clk-synchronous level
- pause_btn  in  1  debounced, clk-synchronous level
- frame_tick  in  1  one-cycle pulse per video frame
- strike_brick  in  1  one-cycle pulse, ball destroyed a brick
- fall_down  in  1  one-cycle pulse, ball passed the paddle
- game_status  out  3  state code (see Behaviour)
- lives_left  out  $clog2(LIVES+1)  remaining lives
- level  out  max(1,$clog2(LEVELS))  current level, 0-based
- bricks_left  out  $clog2(BRICKS+1)  bricks remaining in level
- score  out  SCORE_W  accumulated score
- ball_reset  out  1  one-cycle pulse, re-centre ball on paddle
- ball_en  out  1  ball motion enable

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low on rst_n. All outputs are registered except ball_en, which is decoded from the state register.
- Reset values: state=IDLE, lives_left=LIVES, level=0, bricks_left=BRICKS, score=0, ball_reset=0, frame counter=0, button history regs=0.
- Button edges: start_rise / pause_rise = level & ~previous. Held buttons produce one event only.
- State codes: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LEVEL_CLEAR=4, GAME_OVER=5, WIN=6. ball_en=1 only in PLAY.
- IDLE: on start_rise, reload lives/level/bricks, clear score, pulse ball_reset, go to SERVE.
- SERVE: count frame_tick; when the count reaches SERVE_FRAMES go to PLAY and clear the counter. Latency: SERVE_FRAMES ticks. strike/fall/pause are ignored.
- PLAY, strike_brick: score += BRICK_PTS, saturating at 2^SCORE_W-1; bricks_left-1.
  - If that brick was the last (bricks_left==1): go to WIN when level==LEVELS-1, else go to LEVEL_CLEAR.
- PLAY, fall_down (no last brick this cycle):
  - lives_left==1: lives_left=0, go to GAME_OVER.
  - Otherwise: lives_left-1, pulse ball_reset, go to SERVE.
- PLAY, pause_rise: go to PAUSE.
- PLAY priority within one cycle: last-brick clear > fall_down > pause_rise. A non-final strike_brick is still scored when fall_down or pause_rise fires in the same cycle.
- PAUSE: all strike/fall pulses are masked (no score or life change); pause_rise returns to PLAY. start_rise is ignored.
- LEVEL_CLEAR: count SERVE_FRAMES frame_ticks, then level+1, bricks_left=BRICKS, pulse ball_reset, go to SERVE.
- GAME_OVER / WIN: outputs hold their final values; start_rise goes to IDLE. Score remains visible until the next game start.
- The frame counter clears on every state change.
- rst_n low mid-game forces reset values immediately, independent of clk.
- The FSM never leaves the defined codes; unused codes decode to IDLE.

Decomposition:
- Package game_pkg:
  - state code localparams and GS_W=3
  - helper function for max(1,$clog2(n))
- Sub-module btn_edge: one-bit rising-edge detector with async active-low reset. Instantiated twice (start, pause).

Test Plan:
- Reset, then start_btn held 5 cycles -> single ball_reset pulse, status 0->1; after 2 frame_ticks status=2, lives=3, score=0, bricks=4.
- In PLAY, 4 strike_brick pulses -> score 10,20,30,40; after the 4th, status=4. After 2 ticks: level=1, bricks=4, status=1. Clearing 4 more -> status=6, score=80.
- In PLAY, 3 fall_down pulses (re-serving between them) -> lives 2,1 with status 1 after each; third -> lives=0, status=5. Then start_rise -> status=0.
- pause_rise in PLAY -> status=3. strike_brick and fall_down while paused -> score/lives unchanged. Second pause_rise -> status=2.
- Same-cycle last strike_brick and fall_down (bricks_left=1, level=0) -> status=4, lives unchanged. Same-cycle non-last strike and fall -> score +10, lives-1, status=1.
- SCORE_W=5, BRICK_PTS=10, BRICKS=4: scores 10,20,30,31 (saturated). rst_n pulsed low mid-PLAY -> all outputs at reset values with no clk edge.
